// File: rtl/i2c_eeprom_slave_if.sv
// I2C slave pin-level bus plus the memory write-strobe side channel.
// scl/sda_in come from the bus; the slave drives SDA via sda_out/sda_out_en.
interface i2c_eeprom_slave_if;
    logic       scl;
    logic       sda_in;
    logic       sda_out;
    logic       sda_out_en;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    modport slave (
        input  scl, sda_in,
        output sda_out, sda_out_en, wr_en, wr_addr, wr_data, busy
    );

    modport master (
        output scl, sda_in,
        input  sda_out, sda_out_en, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/i2c_eeprom_slave.sv
// 24Cxx-style I2C EEPROM slave: 256x8 memory, auto-incrementing pointer,
// byte/page write, current/random/sequential read. Never stretches SCL.
module i2c_eeprom_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input logic           clk,
    input logic           rst,
    i2c_eeprom_slave_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, WADDR, ACK_WADDR, WDATA, ACK_WDATA, RDATA, RACK, WAIT_STOP
    } state_t;

    state_t     state;
    logic [2:0] scl_sync, sda_sync;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] ptr;
    logic       rw;
    logic       nack;
    logic       sda_out_r, sda_out_en_r, wr_en_r, busy_r;
    logic [7:0] wr_addr_r, wr_data_r;
    logic [7:0] mem [256];

    logic scl_rise, scl_fall, sda_s, start_det, stop_det, mem_we;
    logic [7:0] rd_byte;

    // [1] is the synchronized level, [2] its one-clk-old copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], bus.scl};
            sda_sync <= {sda_sync[1:0], bus.sda_in};
        end
    end

    assign sda_s     = sda_sync[1];
    assign scl_rise  =  scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] &  scl_sync[2];
    assign start_det =  scl_sync[1] &  scl_sync[2] &  sda_sync[2] & ~sda_sync[1];
    assign stop_det  =  scl_sync[1] &  scl_sync[2] & ~sda_sync[2] &  sda_sync[1];

    assign mem_we  = (state == WDATA) && scl_fall && (bit_cnt == 4'd8) && !start_det && !stop_det;
    assign rd_byte = mem[ptr];

    // Memory has no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr] <= shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            ptr          <= '0;
            rw           <= 1'b0;
            nack         <= 1'b0;
            sda_out_r    <= 1'b1;
            sda_out_en_r <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
            busy_r       <= 1'b0;
        end else begin
            wr_en_r <= 1'b0;
            if (start_det) begin
                state        <= DEV;
                bit_cnt      <= '0;
                busy_r       <= 1'b1;
                sda_out_en_r <= 1'b0;
                sda_out_r    <= 1'b1;
            end else if (stop_det) begin
                state        <= IDLE;
                bit_cnt      <= '0;
                busy_r       <= 1'b0;
                sda_out_en_r <= 1'b0;
                sda_out_r    <= 1'b1;
            end else begin
                case (state)
                    DEV, WADDR, WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == DEV && shreg[7:1] != DEV_ADDR) begin
                                state <= WAIT_STOP;
                            end else begin
                                // ACK is held low from here to the 9th SCL fall.
                                sda_out_en_r <= 1'b1;
                                sda_out_r    <= 1'b0;
                                if (state == DEV) begin
                                    rw    <= shreg[0];
                                    state <= ACK_DEV;
                                end else if (state == WADDR) begin
                                    ptr   <= shreg;
                                    state <= ACK_WADDR;
                                end else begin
                                    wr_en_r   <= 1'b1;
                                    wr_addr_r <= ptr;
                                    wr_data_r <= shreg;
                                    ptr       <= ptr + 8'd1;
                                    state     <= ACK_WDATA;
                                end
                            end
                        end
                    end
                    ACK_DEV, ACK_WADDR, ACK_WDATA: begin
                        if (scl_fall) begin
                            if (state == ACK_DEV && rw) begin
                                state        <= RDATA;
                                shreg        <= {rd_byte[6:0], 1'b0};
                                sda_out_r    <= rd_byte[7];
                                sda_out_en_r <= 1'b1;
                                ptr          <= ptr + 8'd1;
                            end else begin
                                state        <= (state == ACK_DEV) ? WADDR : WDATA;
                                sda_out_en_r <= 1'b0;
                                sda_out_r    <= 1'b1;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt      <= '0;
                                sda_out_en_r <= 1'b0;
                                sda_out_r    <= 1'b1;
                                state        <= RACK;
                            end else begin
                                sda_out_r <= shreg[7];
                                shreg     <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            nack <= sda_s;
                        end else if (scl_fall) begin
                            if (!nack) begin
                                state        <= RDATA;
                                shreg        <= {rd_byte[6:0], 1'b0};
                                sda_out_r    <= rd_byte[7];
                                sda_out_en_r <= 1'b1;
                                ptr          <= ptr + 8'd1;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    IDLE, WAIT_STOP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.sda_out    = sda_out_r;
    assign bus.sda_out_en = sda_out_en_r;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master on an open-drain SDA model,
// scoreboard queues for memory writes and read-back bytes.
module tb_i2c_eeprom_slave;

    localparam int Q = 10;  // quarter SCL period in clk cycles

    typedef logic [7:0] bq_t [$];
    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic m_sda;
    logic ack_en;
    int   errors = 0;
    int   checks = 0;
    wr_t  wr_q [$];
    wr_t  exp_wr;
    logic [7:0] rd_q [$];
    logic [7:0] model [256];

    always #10 clk = ~clk;

    i2c_eeprom_slave_if bus ();

    assign bus.sda_in = m_sda & ~(bus.sda_out_en & ~bus.sda_out);

    i2c_eeprom_slave #(.DEV_ADDR(7'h50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Every wr_en pulse must match the oldest write the stimulus expects.
    always @(negedge clk) begin
        if (!rst && bus.wr_en) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got addr=%h data=%h, none expected", bus.wr_addr, bus.wr_data);
            end else begin
                exp_wr = wr_q.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== exp_wr) begin
                    errors++;
                    $display("FAIL wr_event got addr=%h data=%h, want addr=%h data=%h",
                             bus.wr_addr, bus.wr_data, exp_wr.a, exp_wr.d);
                end
            end
        end
    end

    initial begin
        #1500us;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic qwait(input int n = 1);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qwait();
        bus.scl = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        bus.scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qwait();
        bus.scl = 1'b1; qwait();
        m_sda = 1'b1; qwait(2);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; qwait();
            bus.scl = 1'b1; qwait(2);
            bus.scl = 1'b0; qwait();
        end
        m_sda = 1'b1; qwait();
        bus.scl = 1'b1; qwait();
        ack    = bus.sda_in;
        ack_en = bus.sda_out_en;
        qwait();
        bus.scl = 1'b0; qwait();
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            qwait();
            bus.scl = 1'b1; qwait();
            d[i] = bus.sda_in; qwait();
            bus.scl = 1'b0; qwait();
        end
        m_sda = mack; qwait();
        bus.scl = 1'b1; qwait(2);
        bus.scl = 1'b0; qwait();
        m_sda = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] addr, input bq_t data, output int nacks);
        logic a;
        logic [7:0] wa;
        nacks = 0;
        wa = addr;
        i2c_start();
        send_byte(8'hA0, a); if (a) nacks++;
        send_byte(addr, a);  if (a) nacks++;
        foreach (data[i]) begin
            wr_q.push_back({wa, data[i]});
            model[wa] = data[i];
            wa++;
            send_byte(data[i], a); if (a) nacks++;
        end
        i2c_stop();
    endtask

    task automatic do_read(input logic [7:0] addr, input int n, output bq_t got, output int nacks);
        logic a;
        logic [7:0] ra, d;
        nacks = 0;
        ra = addr;
        got.delete();
        i2c_start();
        send_byte(8'hA0, a); if (a) nacks++;
        send_byte(addr, a);  if (a) nacks++;
        i2c_start();
        send_byte(8'hA1, a); if (a) nacks++;
        for (int i = 0; i < n; i++) begin
            rd_q.push_back(model[ra]);
            ra++;
            recv_byte(i == n - 1, d);
            got.push_back(d);
        end
        i2c_stop();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.scl = 1'b1; m_sda = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.sda_out, bus.sda_out_en, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy} !== {3'b100, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got out=%b en=%b wr_en=%b addr=%h data=%h busy=%b, want 1 0 0 00 00 0",
                     bus.sda_out, bus.sda_out_en, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy);
        end
        rst = 1'b0;
        qwait(2);
    endtask

    task automatic test_byte_write();
        logic a [3];
        i2c_start();
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL bw_busy_start got %b want 1", bus.busy); end
        send_byte(8'hA0, a[0]);
        send_byte(8'h3D, a[1]);
        wr_q.push_back({8'h3D, 8'hBE});
        model[8'h3D] = 8'hBE;
        send_byte(8'hBE, a[2]);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a[i] !== 1'b0) begin errors++; $display("FAIL bw_ack%0d got %b want 0", i, a[i]); end
        end
        i2c_stop();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL bw_busy_stop got %b want 0", bus.busy); end
    endtask

    task automatic test_random_read();
        logic a [3];
        logic [7:0] d, e;
        i2c_start();
        send_byte(8'hA0, a[0]);
        send_byte(8'h3D, a[1]);
        i2c_start();
        send_byte(8'hA1, a[2]);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a[i] !== 1'b0) begin errors++; $display("FAIL rr_ack%0d got %b want 0", i, a[i]); end
        end
        rd_q.push_back(model[8'h3D]);
        recv_byte(1'b1, d);
        e = rd_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL rr_data got %h want %h", d, e); end
        checks++;
        if (bus.sda_out_en !== 1'b0) begin errors++; $display("FAIL rr_release got en=%b want 0", bus.sda_out_en); end
        i2c_stop();
    endtask

    task automatic test_addr_mismatch();
        logic a;
        i2c_start();
        send_byte(8'hA2, a);
        checks++;
        if (a !== 1'b1 || ack_en !== 1'b0) begin
            errors++; $display("FAIL am_devack got ack=%b en=%b want ack=1 en=0", a, ack_en);
        end
        send_byte(8'h3D, a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL am_ignored1 got ack=%b want 1", a); end
        send_byte(8'h77, a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL am_ignored2 got ack=%b want 1", a); end
        i2c_stop();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL am_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_wrap();
        bq_t w, got;
        int  n;
        logic [7:0] e;
        w.push_back(8'h11); w.push_back(8'h22); w.push_back(8'h33);
        do_write(8'hFE, w, n);
        checks++;
        if (n !== 0) begin errors++; $display("FAIL wrap_wr_nacks got %0d want 0", n); end
        do_read(8'hFE, 3, got, n);
        checks++;
        if (n !== 0) begin errors++; $display("FAIL wrap_rd_nacks got %0d want 0", n); end
        foreach (got[i]) begin
            e = rd_q.pop_front();
            checks++;
            if (got[i] !== e) begin errors++; $display("FAIL wrap_rd%0d got %h want %h", i, got[i], e); end
        end
    endtask

    task automatic test_stop_mid_byte();
        bq_t w, got;
        int  n;
        logic a;
        logic [7:0] e;
        logic [7:0] part;
        part = 8'hA5;
        w.push_back(8'h5A);
        do_write(8'h10, w, n);
        checks++;
        if (n !== 0) begin errors++; $display("FAIL smb_pre_nacks got %0d want 0", n); end
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h10, a);
        for (int i = 7; i >= 4; i--) begin
            m_sda = part[i]; qwait();
            bus.scl = 1'b1; qwait(2);
            bus.scl = 1'b0; qwait();
        end
        i2c_stop();
        checks++;
        if (bus.busy !== 1'b0 || bus.sda_out_en !== 1'b0) begin
            errors++; $display("FAIL smb_idle got busy=%b en=%b want 0 0", bus.busy, bus.sda_out_en);
        end
        do_read(8'h10, 1, got, n);
        e = rd_q.pop_front();
        checks++;
        if (n !== 0 || got[0] !== e) begin
            errors++; $display("FAIL smb_readback got %h nacks=%0d want %h nacks=0", got[0], n, e);
        end
    endtask

    task automatic test_reset_mid_read();
        bq_t w, got;
        int  n;
        logic a;
        logic [7:0] e;
        w.push_back(8'h00);
        do_write(8'h20, w, n);
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h20, a);
        i2c_start();
        send_byte(8'hA1, a);
        checks++;
        if (bus.sda_out_en !== 1'b1 || bus.sda_out !== 1'b0) begin
            errors++; $display("FAIL rmr_driving got en=%b out=%b want 1 0", bus.sda_out_en, bus.sda_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.sda_out_en !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rmr_async got en=%b busy=%b want 0 0", bus.sda_out_en, bus.busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_sda = 1'b1; qwait();
        bus.scl = 1'b1; qwait(2);
        w.delete(); w.push_back(8'hC3);
        do_write(8'h21, w, n);
        checks++;
        if (n !== 0) begin errors++; $display("FAIL rmr_wr_nacks got %0d want 0", n); end
        do_read(8'h21, 1, got, n);
        e = rd_q.pop_front();
        checks++;
        if (n !== 0 || got[0] !== e) begin
            errors++; $display("FAIL rmr_readback got %h nacks=%0d want %h nacks=0", got[0], n, e);
        end
    endtask

    task automatic test_back_to_back();
        bq_t w, got;
        int  n;
        logic [7:0] addr, e;
        addr = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) w.push_back(8'($urandom_range(0, 255)));
        do_write(addr, w, n);
        checks++;
        if (n !== 0) begin errors++; $display("FAIL b2b_wr_nacks got %0d want 0", n); end
        do_read(addr, 4, got, n);
        checks++;
        if (n !== 0) begin errors++; $display("FAIL b2b_rd_nacks got %0d want 0", n); end
        foreach (got[i]) begin
            e = rd_q.pop_front();
            checks++;
            if (got[i] !== e) begin errors++; $display("FAIL b2b_rd%0d got %h want %h", i, got[i], e); end
        end
    endtask

    initial begin
        bus.scl = 1'b1;
        m_sda   = 1'b1;
        ack_en  = 1'b0;
        test_reset();
        test_byte_write();
        test_random_read();
        test_addr_mismatch();
        test_wrap();
        test_stop_mid_byte();
        test_reset_mid_read();
        test_back_to_back();
        qwait(2);
        checks++;
        if (wr_q.size() != 0) begin
            errors++; $display("FAIL wr_missing got %0d writes outstanding want 0", wr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_eeprom_slave.md
I2C_EEPROM_SLAVE -- requirements
Module: i2c_eeprom_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, the 7-bit device address (control byte 8'hA0 for write, 8'hA1 for read).
REQ-002 SHALL have port clk, input, 1, system clock (50 MHz); it is the only clock.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port scl, input, 1, I2C clock from the master; the slave never drives it and never stretches the clock.
REQ-005 SHALL have port sda_in, input, 1, sampled SDA line.
REQ-006 SHALL have port sda_out, output, 1, SDA drive value.
REQ-007 SHALL have port sda_out_en, output, 1, SDA drive enable; 0 means the line is released (high-Z).
REQ-008 SHALL have port wr_en, output, 1, one-clk pulse per byte stored to memory.
REQ-009 SHALL have port wr_addr, output, 8, memory address of the byte being stored; valid while wr_en=1.
REQ-010 SHALL have port wr_data, output, 8, byte being stored; valid while wr_en=1.
REQ-011 SHALL have port busy, output, 1, high from START detection to STOP detection.

Function
REQ-012 SHALL pass scl and sda_in through 2-FF synchronizers, then a third register used for edge detection; all decisions use the synchronized signals.
REQ-013 SHALL detect START as synchronized SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-014 SHALL sample data bits MSB first on the SCL rising edge.
REQ-015 SHALL change sda_out/sda_out_en only on an SCL falling edge, so SDA is stable while SCL is high.
REQ-016 SHALL hold a 256x8 internal memory and an 8-bit address pointer; memory contents are not reset.
REQ-017 SHALL implement states IDLE, DEV, ACK_DEV, WADDR, ACK_WADDR, WDATA, ACK_WDATA, RDATA, RACK and WAIT_STOP.
REQ-018 State IDLE: START -> DEV, with the bit counter cleared.
REQ-019 State DEV: after 8 bits, if bits[7:1]==DEV_ADDR -> ACK_DEV; otherwise -> WAIT_STOP with SDA released (no ACK).
REQ-020 ACK state behaviour: in ACK_DEV, ACK_WADDR and ACK_WDATA, sda_out_en=1 and sda_out=0 from the 8th-bit SCL falling edge to the 9th-bit SCL falling edge.
REQ-021 Exit from ACK_DEV: R/W=0 -> WADDR; R/W=1 -> RDATA.
REQ-022 State WADDR: the received byte loads the pointer -> ACK_WADDR -> WDATA.
REQ-023 State WDATA: after 8 bits, write mem[pointer], pulse wr_en with wr_addr=pointer and wr_data=byte, increment the pointer, then -> ACK_WDATA -> WDATA.
REQ-024 State RDATA: load the shift register from mem[pointer] at entry and increment the pointer; drive each bit (sda_out_en=1, sda_out=bit); after the 8th bit, release SDA -> RACK.
REQ-025 State RACK: sample SDA on the 9th SCL rise; 0 (ACK) -> RDATA with the next byte; 1 (NACK) -> WAIT_STOP.
REQ-026 State WAIT_STOP: SDA released; only START or STOP is acted upon.
REQ-027 A START in any state (repeated START) SHALL -> DEV, with the pointer retained, enabling random read.
REQ-028 A STOP in any state SHALL -> IDLE, release SDA and abort any partial byte; a partial WDATA byte is not written.
REQ-029 The pointer SHALL wrap 8'hFF -> 8'h00 on both writes and reads.
REQ-030 START/STOP detection SHALL take priority over bit sampling in the same clk cycle.
REQ-031 Response latency from a pin edge to the internal action SHALL be 3 clk cycles, and to the sda_out/sda_out_en change SHALL be at most 4 clk cycles.

Reset
REQ-032 While rst=1, outputs SHALL be: sda_out=1, sda_out_en=0, wr_en=0, wr_addr=0, wr_data=0, busy=0; state=IDLE, pointer=0, counters=0, synchronizer registers=1.
REQ-033 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously), without waiting for an SCL edge.
REQ-034 After reset, the block SHALL ignore bus activity until the next START.

Verification
REQ-035 Byte write: START, A0, 3D, BE, STOP -> three ACKs; one wr_en pulse with wr_addr=3D, wr_data=BE; busy falls after STOP.
REQ-036 Random read: START, A0, 3D, repeated START, A1, read with master NACK, STOP -> rd byte=BE, SDA released after the NACK, no wr_en.
REQ-037 Address mismatch: START, A2 -> sda_out_en stays 0 for the 9th bit; the following bytes are ignored until STOP; no wr_en.
REQ-038 Wrap: write FE with data 11, 22, 33 -> wr_en at addresses FE, FF, 00; a sequential read from FE with ACK, ACK, NACK returns 11, 22, 33.
REQ-039 STOP mid-byte: START, A0, 10, 4 bits of data, STOP -> no wr_en; state IDLE; a subsequent read at 10 returns the previous contents.
REQ-040 Reset mid-read: rst asserted while driving a 0 data bit -> sda_out_en=0 within the same cycle; busy=0; the next transaction completes normally.
